// File: rtl/debounce_multi_pkg.sv
// Shared constants and helpers for the multi-channel button debouncer.
// Everything here is elaboration-time only.
package debounce_pkg;

    localparam int DEF_CLK_FREQ    = 100_000_000;
    localparam int TICK_MS         = 1;
    localparam int DEF_DEBOUNCE_MS = 20;
    localparam int DEF_LONG_MS     = 1000;

    localparam int DEF_DCNT_W = $clog2(DEF_DEBOUNCE_MS + 1);
    localparam int DEF_HCNT_W = $clog2(DEF_LONG_MS + 1);

    function automatic int tick_div(input int clk_freq);
        return clk_freq / (1000 * TICK_MS);
    endfunction

    // Width of a counter that must hold 0..max_val, never narrower than 1
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Pad-side and event-side signals of the debouncer, one bit per channel.
// master = pads/consumers, slave = the debounce block.
interface debounce_multi_if #(
    parameter int N_CH = 5
);

    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_out;
    logic [N_CH-1:0] btn_rise;
    logic [N_CH-1:0] btn_fall;
    logic [N_CH-1:0] btn_long;

    modport master (
        output btn_in,
        input  btn_out,
        input  btn_rise,
        input  btn_fall,
        input  btn_long
    );

    modport slave (
        input  btn_in,
        output btn_out,
        output btn_rise,
        output btn_fall,
        output btn_long
    );

endinterface

// File: rtl/debounce_multi_ch.sv
// One debounce channel: synchroniser, debounce counter, clean level,
// edge pulses and long-press pulse, all advanced by a shared ms tick.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
    parameter int LONG_MS     = DEF_LONG_MS,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_in,
    output logic btn_out,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_long
);

    localparam int DW = cnt_w(DEBOUNCE_MS);
    localparam int HW = cnt_w(LONG_MS);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_MS - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(LONG_MS);

    logic          s1;
    logic          s2;
    logic          lvl;
    logic          agree;
    logic          d_roll;
    logic          d_inc;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;

    assign lvl    = s2 ^ ACTIVE_LOW;
    assign agree  = (lvl == btn_out);
    assign d_roll = !agree && tick && (dcnt == D_LAST);
    assign d_inc  = !agree && tick && (dcnt != D_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= ACTIVE_LOW;
            s2       <= ACTIVE_LOW;
            dcnt     <= '0;
            hcnt     <= '0;
            btn_out  <= 1'b0;
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            btn_long <= 1'b0;
        end else begin
            s1       <= btn_in;
            s2       <= s1;
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            btn_long <= 1'b0;

            // Any cycle of agreement restarts the count, tick or not
            unique case (1'b1)
                agree: dcnt <= '0;
                d_roll: begin
                    btn_out  <= lvl;
                    btn_rise <= lvl;
                    btn_fall <= ~lvl;
                    dcnt     <= '0;
                end
                d_inc: dcnt <= dcnt + 1'b1;
                default: ;
            endcase

            // Saturating hold counter gives one long pulse per press
            if (!btn_out) begin
                hcnt <= '0;
            end else if (tick && (hcnt != H_MAX)) begin
                hcnt     <= hcnt + 1'b1;
                btn_long <= (hcnt == H_LAST);
            end
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: one shared 1 ms prescaler feeding N_CH
// independent debounce channels.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH        = 5,
    parameter int CLK_FREQ    = DEF_CLK_FREQ,
    parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
    parameter int LONG_MS     = DEF_LONG_MS,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    debounce_multi_if.slave   bus
);

    localparam int TDIV = tick_div(CLK_FREQ);
    localparam int PW   = cnt_w(TDIV - 1);

    localparam logic [PW-1:0] P_LAST = PW'(TDIV - 1);

    if (CLK_FREQ % 1000 != 0) begin : g_bad_freq
        $error("debounce_multi: CLK_FREQ must be a multiple of 1000");
    end
    if (DEBOUNCE_MS < 1) begin : g_bad_deb
        $error("debounce_multi: DEBOUNCE_MS must be >= 1");
    end
    if (LONG_MS <= DEBOUNCE_MS) begin : g_bad_long
        $error("debounce_multi: LONG_MS must exceed DEBOUNCE_MS");
    end
    if (N_CH < 1) begin : g_bad_nch
        $error("debounce_multi: N_CH must be >= 1");
    end

    logic [PW-1:0]   pcnt;
    logic            tick;
    logic [N_CH-1:0] out_v;
    logic [N_CH-1:0] rise_v;
    logic [N_CH-1:0] fall_v;
    logic [N_CH-1:0] long_v;

    assign tick = (pcnt == P_LAST);

    // Free-running so every channel sees the same tick phase
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .btn_in   (bus.btn_in[i]),
            .btn_out  (out_v[i]),
            .btn_rise (rise_v[i]),
            .btn_fall (fall_v[i]),
            .btn_long (long_v[i])
        );
    end

    assign bus.btn_out  = out_v;
    assign bus.btn_rise = rise_v;
    assign bus.btn_fall = fall_v;
    assign bus.btn_long = long_v;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench: table of level/pulse vectors plus timed sequences
// for press, bounce, long press, reset and active-low inputs.
module tb_debounce_multi;

    logic clk;
    logic rst;

    debounce_multi_if #(.N_CH(3)) bus_a ();
    debounce_multi_if #(.N_CH(1)) bus_b ();

    debounce_multi #(
        .N_CH        (3),
        .CLK_FREQ    (10_000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (10),
        .ACTIVE_LOW  (1'b0)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    debounce_multi #(
        .N_CH        (1),
        .CLK_FREQ    (10_000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (10),
        .ACTIVE_LOW  (1'b1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] btn;
        int         hold;
        logic [2:0] out;
        logic [2:0] rise;
        logic [2:0] fall;
        logic [2:0] lng;
    } vec_t;

    vec_t tbl [9];

    int checks;
    int failures;
    int cyc_n;
    int both_err;
    int rise_cnt [4];
    int fall_cnt [4];
    int long_cnt [4];
    int rise_at  [4];
    int fall_at  [4];
    int long_at  [4];

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", nm, got, exp, cyc_n);
        end
    endtask

    task automatic clr();
        for (int c = 0; c < 4; c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
            long_cnt[c] = 0;
            rise_at[c]  = -1;
            fall_at[c]  = -1;
            long_at[c]  = -1;
        end
    endtask

    // One clock; outputs sampled on the falling edge
    task automatic cyc();
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] l;
        @(negedge clk);
        cyc_n++;
        r = {bus_b.btn_rise[0], bus_a.btn_rise};
        f = {bus_b.btn_fall[0], bus_a.btn_fall};
        l = {bus_b.btn_long[0], bus_a.btn_long};
        for (int c = 0; c < 4; c++) begin
            if (r[c]) begin
                rise_cnt[c]++;
                rise_at[c] = cyc_n;
            end
            if (f[c]) begin
                fall_cnt[c]++;
                fall_at[c] = cyc_n;
            end
            if (l[c]) begin
                long_cnt[c]++;
                long_at[c] = cyc_n;
            end
            if (r[c] && f[c]) both_err++;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc_n < target) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        cyc_n = 0;
        clr();
    endtask

    // Ticks land at cycles that are multiples of 10 after reset;
    // the counters first see an input driven at cycle c on cycle c+3.
    function automatic int exp_edge(input int c, input int n);
        int j0;
        j0 = ((c + 3 + 9) / 10) * 10;
        return j0 + (n - 1) * 10;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        both_err = 0;
        cyc_n    = 0;
        clr();

        tbl[0] = '{3'b001, 45, 3'b001, 3'b001, 3'b000, 3'b000};
        tbl[1] = '{3'b000, 20, 3'b001, 3'b000, 3'b000, 3'b000};
        tbl[2] = '{3'b001, 20, 3'b001, 3'b000, 3'b000, 3'b000};
        tbl[3] = '{3'b000, 45, 3'b000, 3'b000, 3'b001, 3'b000};
        tbl[4] = '{3'b110, 45, 3'b110, 3'b110, 3'b000, 3'b000};
        tbl[5] = '{3'b011, 45, 3'b011, 3'b001, 3'b100, 3'b000};
        tbl[6] = '{3'b000, 45, 3'b000, 3'b000, 3'b011, 3'b000};
        tbl[7] = '{3'b100, 30, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[8] = '{3'b000, 45, 3'b000, 3'b000, 3'b000, 3'b000};

        rst          = 1'b1;
        bus_a.btn_in = 3'b000;
        bus_b.btn_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_a",  int'(bus_a.btn_out),  0);
        chk("rst_rise_a", int'(bus_a.btn_rise), 0);
        chk("rst_fall_a", int'(bus_a.btn_fall), 0);
        chk("rst_long_a", int'(bus_a.btn_long), 0);
        chk("rst_out_b",  int'(bus_b.btn_out),  0);
        rst   = 1'b0;
        cyc_n = 0;

        for (int i = 0; i < 9; i++) begin
            clr();
            bus_a.btn_in = tbl[i].btn;
            repeat (tbl[i].hold) cyc();
            chk($sformatf("t%0d_out", i), int'(bus_a.btn_out), int'(tbl[i].out));
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("t%0d_rise%0d", i, c), rise_cnt[c], int'(tbl[i].rise[c]));
                chk($sformatf("t%0d_fall%0d", i, c), fall_cnt[c], int'(tbl[i].fall[c]));
                chk($sformatf("t%0d_long%0d", i, c), long_cnt[c], int'(tbl[i].lng[c]));
            end
        end
        chk("idle_b_out", int'(bus_b.btn_out), 0);

        // Clean press on ch0 with known tick phase
        do_reset();
        run_to(5);
        bus_a.btn_in[0] = 1'b1;
        run_to(55);
        chk("press_rise_at", rise_at[0], exp_edge(5, 4));
        chk("press_rise_n",  rise_cnt[0], 1);
        chk("press_out",     int'(bus_a.btn_out[0]), 1);
        chk("press_others",  rise_cnt[1] + rise_cnt[2], 0);

        // Bounce on ch1 every 7 cycles, settling high
        bus_a.btn_in = 3'b000;
        clr();
        begin
            int cs;
            cs = cyc_n;
            for (int k = 0; k < 29; k++) begin
                bus_a.btn_in[1] = (k % 2 == 0);
                repeat (7) cyc();
            end
            run_to(cs + 196 + 60);
            chk("bounce_rise_n",  rise_cnt[1], 1);
            chk("bounce_rise_at", rise_at[1], exp_edge(cs + 196, 4));
            chk("bounce_fall_n",  fall_cnt[1], 0);
            chk("bounce_out",     int'(bus_a.btn_out[1]), 1);
        end

        // Long press on ch2, then release
        bus_a.btn_in = 3'b000;
        do_reset();
        run_to(3);
        bus_a.btn_in[2] = 1'b1;
        run_to(260);
        bus_a.btn_in[2] = 1'b0;
        run_to(320);
        chk("long_rise_at", rise_at[2], exp_edge(3, 4));
        chk("long_at",      long_at[2], exp_edge(3, 4) + 100);
        chk("long_n",       long_cnt[2], 1);
        chk("long_fall_at", fall_at[2], exp_edge(260, 4));
        chk("long_fall_n",  fall_cnt[2], 1);

        // Short press on ch0, about 6 ticks high
        clr();
        bus_a.btn_in[0] = 1'b1;
        run_to(380);
        bus_a.btn_in[0] = 1'b0;
        run_to(440);
        chk("short_rise_at", rise_at[0], exp_edge(320, 4));
        chk("short_fall_at", fall_at[0], exp_edge(380, 4));
        chk("short_long_n",  long_cnt[0], 0);
        chk("short_rise_n",  rise_cnt[0], 1);

        // Reset while ch0 is mid-count and ch1 is in long-hold
        do_reset();
        bus_a.btn_in[1] = 1'b1;
        run_to(62);
        bus_a.btn_in[0] = 1'b1;
        run_to(85);
        chk("mid_pre_rise_at", rise_at[1], 40);
        rst             = 1'b1;
        bus_a.btn_in[0] = 1'b0;
        clr();
        cyc();
        chk("mid_rst_out",  int'(bus_a.btn_out),  0);
        chk("mid_rst_rise", int'(bus_a.btn_rise), 0);
        chk("mid_rst_fall", int'(bus_a.btn_fall), 0);
        chk("mid_rst_long", int'(bus_a.btn_long), 0);
        rst   = 1'b0;
        cyc_n = 0;
        clr();
        run_to(60);
        chk("mid_rise_at",  rise_at[1], exp_edge(0, 4));
        chk("mid_rise_n",   rise_cnt[1], 1);
        chk("mid_ch0_rise", rise_cnt[0], 0);
        chk("mid_fall_n",   fall_cnt[0] + fall_cnt[1] + fall_cnt[2], 0);

        // Active-low instance: idle high, press by driving low
        chk("al_idle_out", int'(bus_b.btn_out), 0);
        bus_b.btn_in = 1'b0;
        run_to(120);
        chk("al_rise_at", rise_at[3], exp_edge(60, 4));
        chk("al_out",     int'(bus_b.btn_out), 1);
        bus_b.btn_in = 1'b1;
        run_to(170);
        chk("al_fall_at", fall_at[3], exp_edge(120, 4));
        chk("al_out_rel", int'(bus_b.btn_out), 0);

        chk("rise_fall_excl", both_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel successor to the single-button debouncer. Serves all board buttons and switches from one block.
- Each channel has a 2-flop synchroniser, a debounce counter driven by a shared 1 ms tick, registered clean level, one-cycle rise/fall pulses and a long-press pulse.
- Sits between raw pad inputs and the ALU control/operand-select logic. Consumers see single-cycle events instead of doing their own edge detection.

Parameters:
- N_CH, 5, number of independent input channels (>=1).
- CLK_FREQ, 100_000_000, clk frequency in Hz; must be a multiple of 1000.
- DEBOUNCE_MS, 20, ticks of continuous disagreement required before btn_out follows the input (>=1).
- LONG_MS, 1000, ticks btn_out must stay high before btn_long fires (> DEBOUNCE_MS).
- ACTIVE_LOW, 0, 1 = raw inputs are active-low; inverted after synchronisation.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- btn_in  in  N_CH  raw asynchronous inputs.
- btn_out  out  N_CH  debounced level, 1 = pressed.
- btn_rise  out  N_CH  one-cycle pulse on debounced press.
- btn_fall  out  N_CH  one-cycle pulse on debounced release.
- btn_long  out  N_CH  one-cycle pulse when press held LONG_MS ticks.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values (rst high at a posedge):
  - btn_out, btn_rise, btn_fall, btn_long = 0.
  - All counters = 0. Prescaler = 0.
  - Sync flops load the inactive raw level: 0, or 1 when ACTIVE_LOW.
- Reset mid-operation: everything is cleared in that cycle with no pulses emitted. A button still pressed after reset re-debounces from zero.
- Synchroniser: s1 <= btn_in; s2 <= s1; lvl = s2 ^ ACTIVE_LOW. This gives 2 cycles of latency before the counters see a change.
- Prescaler:
  - TICK_DIV = CLK_FREQ/1000. Counter runs 0..TICK_DIV-1 and wraps.
  - tick = 1 for exactly one cycle when count == TICK_DIV-1.
  - Shared by all channels; free-running, not gated by input activity.
- Per-channel debounce counter, dcnt, width clog2(DEBOUNCE_MS+1):
  - lvl == btn_out: dcnt <= 0 every cycle, regardless of tick. Any glitch restarts the count.
  - lvl != btn_out and tick and dcnt == DEBOUNCE_MS-1: btn_out <= lvl, dcnt <= 0.
  - lvl != btn_out and tick otherwise: dcnt <= dcnt+1.
  - lvl != btn_out and no tick: hold.
  - Result: btn_out changes on the DEBOUNCE_MS-th tick of continuous disagreement. Required stable time is between DEBOUNCE_MS-1 and DEBOUNCE_MS ms.
- Edge pulses:
  - btn_rise / btn_fall are registered together with btn_out. They are high exactly in the first cycle btn_out shows the new value, then 0.
  - Only one of rise/fall can be high per channel per cycle.
- Long press, hcnt of width clog2(LONG_MS+1):
  - While btn_out == 1, hcnt increments on tick, saturating at LONG_MS.
  - btn_long pulses for one cycle on the tick where hcnt goes LONG_MS-1 -> LONG_MS. Once per press, no auto-repeat.
  - hcnt <= 0 in any cycle btn_out == 0, including the btn_fall cycle.
- Channel independence: channels share only the tick. Simultaneous events on several channels each produce their own pulses in the same cycle.
- Elaboration checks: CLK_FREQ % 1000 == 0, DEBOUNCE_MS >= 1, LONG_MS > DEBOUNCE_MS. Violations raise an elaboration-time error.

Decomposition:
- Package debounce_pkg:
  - function tick_div(clk_freq).
  - Counter-width constants derived with $clog2.
  - Default CLK_FREQ and TICK_MS constants.
- Sub-module debounce_ch: one channel holding the sync flops, dcnt, hcnt, btn_out and the pulses. Takes tick as input.
- Top debounce_multi: owns the prescaler and a generate loop of N_CH debounce_ch instances.

Test Plan (bench params: CLK_FREQ=10_000 so TICK_DIV=10, DEBOUNCE_MS=4, LONG_MS=10, N_CH=3):
- Clean press: ch0 0->1 and held. btn_out[0] rises on the 4th tick after lvl flips, i.e. 30-40 cycles after the input edge. btn_rise[0] is a single cycle coincident with it; ch1/ch2 stay 0.
- Bounce: ch1 toggles every 7 cycles for 200 cycles, then settles high. No btn_out/btn_rise activity during bouncing; exactly one btn_rise[1] 4 ticks after the last edge.
- Long press: ch2 held high. btn_long[2] pulses once exactly 10 ticks after btn_rise[2] and never again while held. On release, btn_fall[2] follows 4 ticks later.
- Short press: ch0 held 6 ticks. One rise and one fall, no btn_long.
- Reset mid-count: assert rst for 1 cycle while dcnt[0]=2 and ch1 is in long-hold. All outputs are 0 the next cycle with no pulses. Held ch1 re-debounces and gives btn_rise[1] 4 ticks after rst drops.
- ACTIVE_LOW=1 rerun: input idle at 1 gives btn_out=0. Driving 0 gives btn_rise after 4 ticks.
